// File: rtl/axi4lite_apb_bridge_pkg.sv
// Shared types and constants for the AXI4-Lite to APB bridge.
// Pure declarations, no timing.
// No flow control of its own; used by the bridge FSM only.
package axi_apb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_ACCESS = 3'd2,
    ST_WRESP  = 3'd3,
    ST_RRESP  = 3'd4
  } bridge_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi4lite_apb_bridge.sv
// Single-outstanding AXI4-Lite slave to APB master bridge, one APB transfer per AXI request.
// Latency: response valid 3 cycles after the accept cycle with zero APB wait states.
// Backpressure: one transfer in flight; no new request until the B/R handshake, APB waits stall indefinitely.
module axi4lite_apb_bridge
  import axi_apb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_awvalid,
  output logic                in_awready,
  input  logic [ADDR_W-1:0]   in_awaddr,
  input  logic [2:0]          in_awprot,
  input  logic                in_wvalid,
  output logic                in_wready,
  input  logic [DATA_W-1:0]   in_wdata,
  input  logic [DATA_W/8-1:0] in_wstrb,
  output logic                in_bvalid,
  input  logic                in_bready,
  output logic [1:0]          in_bresp,
  input  logic                in_arvalid,
  output logic                in_arready,
  input  logic [ADDR_W-1:0]   in_araddr,
  input  logic [2:0]          in_arprot,
  output logic                in_rvalid,
  input  logic                in_rready,
  output logic [DATA_W-1:0]   in_rdata,
  output logic [1:0]          in_rresp,
  output logic [ADDR_W-1:0]   out_paddr,
  output logic                out_psel,
  output logic                out_penable,
  output logic [2:0]          out_pprot,
  output logic                out_pwrite,
  output logic [DATA_W-1:0]   out_pwdata,
  output logic [DATA_W/8-1:0] out_pstrb,
  input  logic                out_pready,
  input  logic [DATA_W-1:0]   out_prdata,
  input  logic                out_pslverr
);

  bridge_state_e state;
  logic          wr_take;
  logic          rd_take;
  logic [1:0]    resp;

  // Accept decisions: AW and W only together, and a pending write beats a read.
  always_comb begin
    wr_take = (state == ST_IDLE) && in_awvalid && in_wvalid;
    rd_take = (state == ST_IDLE) && in_arvalid && !(in_awvalid && in_wvalid);
  end

  assign in_awready = wr_take;
  assign in_wready  = wr_take;
  assign in_arready = rd_take;

  // One response register serves both channels; only one of B/R is ever valid.
  assign in_bresp = resp;
  assign in_rresp = resp;

  // Bridge FSM with registered APB request and AXI response outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      out_paddr   <= '0;
      out_pprot   <= '0;
      out_pwrite  <= 1'b0;
      out_pwdata  <= '0;
      out_pstrb   <= '0;
      out_psel    <= 1'b0;
      out_penable <= 1'b0;
      in_bvalid   <= 1'b0;
      in_rvalid   <= 1'b0;
      in_rdata    <= '0;
      resp        <= RESP_OKAY;
    end else begin
      case (state)
        ST_IDLE: begin
          if (wr_take) begin
            out_paddr  <= in_awaddr;
            out_pprot  <= in_awprot;
            out_pwrite <= 1'b1;
            out_pwdata <= in_wdata;
            out_pstrb  <= in_wstrb;
            out_psel   <= 1'b1;
            state      <= ST_SETUP;
          end else if (rd_take) begin
            // Reads leave pwdata untouched and drive no strobes.
            out_paddr  <= in_araddr;
            out_pprot  <= in_arprot;
            out_pwrite <= 1'b0;
            out_pstrb  <= '0;
            out_psel   <= 1'b1;
            state      <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          out_penable <= 1'b1;
          state       <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (out_pready) begin
            out_psel    <= 1'b0;
            out_penable <= 1'b0;
            resp        <= out_pslverr ? RESP_SLVERR : RESP_OKAY;
            if (out_pwrite) begin
              in_bvalid <= 1'b1;
              state     <= ST_WRESP;
            end else begin
              in_rvalid <= 1'b1;
              in_rdata  <= out_prdata;
              state     <= ST_RRESP;
            end
          end
        end
        ST_WRESP: begin
          if (in_bready) begin
            in_bvalid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        ST_RRESP: begin
          if (in_rready) begin
            in_rvalid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
